pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined multi-mode barrel shifter for the CPU execute path and the DSP/datapath blocks. It supports logical left, logical right, arithmetic right, rotate left and rotate right. The block is a log2(WIDTH)-deep pipeline, one mux level per stage, with a valid/ready handshake and a global stall for backpressure. A sideband tag travels with each operation so the consumer can match results to issuing instructions.

Parameters:
WIDTH, 32, data width in bits; power of two, minimum 4
SHAMT_W, $clog2(WIDTH), shift-amount width; derived, must not be overridden
TAG_W, 5, sideband tag width, e.g. destination register number

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
in_data  input  WIDTH  operand
in_shamt  input  SHAMT_W  shift amount, unsigned
in_mode  input  3  operation select
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  shifted result
out_tag  output  TAG_W  tag of the result
out_err  output  1  request used a reserved mode

Behaviour:
- Mode encoding: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR. Codes 101, 110 and 111 are reserved: out_data equals in_data unshifted and out_err=1.
- Fill rules:
  - SLL and SRL fill with 0.
  - SRA fills with the MSB of the original in_data. The sign is captured at entry and carried down the pipeline.
  - ROL and ROR recirculate bits.
- Shift amount 0 returns in_data unchanged in all modes.
- Pipeline has SHAMT_W stages. Stage k (k=0 first) shifts or rotates by 2^(SHAMT_W-1-k) when the corresponding bit of the captured shamt is set, so the largest shift is applied first.
  - Each stage registers data, remaining shamt bits, mode, sign, tag, err and a valid bit.
  - Latency: a request accepted at edge N appears on out_* after edge N+SHAMT_W-1, i.e. SHAMT_W cycles from in_valid&in_ready to out_valid, with no stall. WIDTH=32 gives 5 cycles.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - On advance, every stage loads from its predecessor, and stage 0 loads the request with valid = in_valid.
  - When advance=0, all stages hold, including bubbles.
  - Throughput is 1 op/cycle when out_ready is held high.
  - A transfer occurs on out_valid&out_ready. out_data, out_tag and out_err stay stable while out_valid=1 and out_ready=0.
  - in_data, in_shamt, in_mode and in_tag are sampled only when in_valid&in_ready.
- Simultaneous events: an accept and an output transfer in the same cycle is the normal streaming case. No operation is lost or duplicated, and order is strictly FIFO.
- Reset (reset=0 at a rising edge):
  - All stage valid bits clear to 0 and all data, tag and err registers clear to 0.
  - Reset values: out_valid=0, out_data=0, out_tag=0, out_err=0. in_ready reads 1 from the first cycle after reset.
  - Reset mid-operation discards every in-flight op, and none emerge afterwards. in_valid is ignored while reset=0.
- No X propagation: bubble stages still carry defined (held or zero) data.

Decomposition:
- Package shifter_pkg holds:
  - mode constants MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR
  - function is_reserved_mode
  - mode width constant MODE_W=3
- Sub-module shift_stage: one mux level plus pipeline register.
  - Parameters: WIDTH, DIST (shift distance 2^n), TAG_W, SHAMT_W.
  - Ports: clock, reset, enable, shift-bit select, and the carried fields in/out.
- The top generates SHAMT_W instances of shift_stage and holds the handshake logic.

Test Plan:
- SLL 0x0000_0001 by 31, out_ready=1 → exactly 5 cycles later out_data=0x8000_0000, out_err=0, tag echoed. SRL 0xFFFF_FFFF by 31 → 0x0000_0001; SRL by 0 → 0xFFFF_FFFF.
- SRA 0x8000_00F0 by 4 → 0xF800_000F; SRA 0x7000_0000 by 4 → 0x0700_0000. ROR 0x1234_5678 by 8 → 0x7812_3456; ROL 0x8000_0001 by 1 → 0x0000_0003.
- Stream 8 back-to-back ops with tags 0..7 and drop out_ready for 3 cycles mid-stream → in_ready low for exactly those 3 cycles, outputs held stable while stalled, all 8 results arrive in tag order 0..7 with none dropped or duplicated.
- Issue 3 ops, assert reset=0 for one edge while they are in flight → next cycle out_valid=0 and out_data=0, and none of the 3 tags ever appear afterwards.
- Reserved mode 3'b111 with in_data=0xDEAD_BEEF, shamt=7 → out_data=0xDEAD_BEEF, out_err=1. A following valid SLL op reports out_err=0.
- Instance with WIDTH=8 (3 stages): ROL 0x81 by 4 → 0x18, SRA 0x90 by 3 → 0xF2, latency 3 cycles, plus a randomized comparison against a behavioural model over 10k ops with random out_ready.

Source files
------------

// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the reserved-mode decode used at pipeline entry.
package shifter_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_SLL = 3'b000,
    MODE_SRL = 3'b001,
    MODE_SRA = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } mode_e;

  function automatic logic is_reserved_mode(input logic [MODE_W-1:0] mode);
    return !(mode inside {MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR});
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Request/result bundle of the barrel shifter; the producer/consumer side
// uses the master modport, the shifter itself the slave modport.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  import shifter_pkg::*;

  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [MODE_W-1:0]  in_mode;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_err;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

endinterface

// File: rtl/pipelined_barrel_shifter_stage.sv
// One barrel-shifter level: conditionally shifts/rotates by DIST, then
// registers the result together with every field that travels with the op.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIST    = 1,
  parameter int TAG_W   = 5,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_i,
  input  logic               sel_i,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [MODE_W-1:0]  mode_i,
  input  logic               sign_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               err_i,
  output logic               valid_o,
  output logic [WIDTH-1:0]   data_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output logic [MODE_W-1:0]  mode_o,
  output logic               sign_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic               err_o
);

  logic [WIDTH-1:0]   data_d;
  logic               valid_q;
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [MODE_W-1:0]  mode_q;
  logic               sign_q;
  logic [TAG_W-1:0]   tag_q;
  logic               err_q;

  // NOTE: data_d gets its default before the case so no latch is inferred.
  always_comb begin
    data_d = data_i;
    if (sel_i && !err_i) begin
      unique case (mode_i)
        MODE_SLL: data_d = data_i << DIST;
        MODE_SRL: data_d = data_i >> DIST;
        MODE_SRA: data_d = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
        MODE_ROL: data_d = {data_i[WIDTH-1-DIST:0], data_i[WIDTH-1:WIDTH-DIST]};
        MODE_ROR: data_d = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
        default:  data_d = data_i;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments; the synchronous reset clears
  // payload as well as valid so no stage ever carries undefined data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else if (enable_i) begin
      valid_q <= valid_i;
      // Bubbles leave the payload untouched so idle inputs are never sampled.
      if (valid_i) begin
        data_q  <= data_d;
        shamt_q <= shamt_i;
        mode_q  <= mode_i;
        sign_q  <= sign_i;
        tag_q   <= tag_i;
        err_q   <= err_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign mode_o  = mode_q;
  assign sign_o  = sign_q;
  assign tag_o   = tag_q;
  assign err_o   = err_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined multi-mode barrel shifter: log2(WIDTH) shift stages, largest
// distance first, with a valid/ready handshake and a global stall.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic                       clock,
  input logic                       reset,
  pipelined_barrel_shifter_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  // Index 0 is the incoming request, index k+1 the output of stage k.
  logic               valid_s [SHAMT_W+1];
  logic [WIDTH-1:0]   data_s  [SHAMT_W+1];
  logic [SHAMT_W-1:0] shamt_s [SHAMT_W+1];
  logic [MODE_W-1:0]  mode_s  [SHAMT_W+1];
  logic               sign_s  [SHAMT_W+1];
  logic [TAG_W-1:0]   tag_s   [SHAMT_W+1];
  logic               err_s   [SHAMT_W+1];
  logic               advance;
  logic               unused_tail;

  assign advance = !valid_s[SHAMT_W] || bus.out_ready;

  assign valid_s[0] = bus.in_valid;
  assign data_s[0]  = bus.in_data;
  assign shamt_s[0] = bus.in_shamt;
  assign mode_s[0]  = bus.in_mode;
  assign sign_s[0]  = bus.in_data[WIDTH-1];
  assign tag_s[0]   = bus.in_tag;
  assign err_s[0]   = is_reserved_mode(bus.in_mode);

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH  (WIDTH),
      .DIST   (1 << (SHAMT_W - 1 - k)),
      .TAG_W  (TAG_W),
      .SHAMT_W(SHAMT_W)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .enable_i(advance),
      .sel_i   (shamt_s[k][SHAMT_W-1-k]),
      .valid_i (valid_s[k]),
      .data_i  (data_s[k]),
      .shamt_i (shamt_s[k]),
      .mode_i  (mode_s[k]),
      .sign_i  (sign_s[k]),
      .tag_i   (tag_s[k]),
      .err_i   (err_s[k]),
      .valid_o (valid_s[k+1]),
      .data_o  (data_s[k+1]),
      .shamt_o (shamt_s[k+1]),
      .mode_o  (mode_s[k+1]),
      .sign_o  (sign_s[k+1]),
      .tag_o   (tag_s[k+1]),
      .err_o   (err_s[k+1])
    );
  end

  // The last stage's control fields have no consumer.
  assign unused_tail = ^{shamt_s[SHAMT_W], mode_s[SHAMT_W], sign_s[SHAMT_W]};

  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_s[SHAMT_W];
  assign bus.out_data  = data_s[SHAMT_W];
  assign bus.out_tag   = tag_s[SHAMT_W];
  assign bus.out_err   = err_s[SHAMT_W];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed vector table plus scoreboarded streaming,
// stall, reset and randomized runs on a 32-bit and an 8-bit instance.
module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
    int          cyc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [31:0] din;
    logic [4:0]  shamt;
    logic [2:0]  mode;
    logic [31:0] dout;
    logic        err;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_low32 = 0;
  int   outs32 = 0;
  int   outs8 = 0;
  bit   rnd_done = 1'b0;
  exp_t sb32[$];
  exp_t sb8[$];
  vec_t vecs[13];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  pipelined_barrel_shifter_if #(.WIDTH(32), .TAG_W(5)) b32 ();
  pipelined_barrel_shifter_if #(.WIDTH(8),  .TAG_W(5)) b8 ();

  pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(5)) dut32 (
    .clock(clock), .reset(reset), .bus(b32)
  );
  pipelined_barrel_shifter #(.WIDTH(8), .TAG_W(5)) dut8 (
    .clock(clock), .reset(reset), .bus(b8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour for width w (w <= 32); returns {err, data}.
  function automatic logic [32:0] model(input int w, input logic [31:0] d,
                                        input int sh, input logic [2:0] m);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (m)
      3'b000: r = (d << sh) & mask;
      3'b001: r = d >> sh;
      3'b010: begin
        r = d >> sh;
        if (d[w-1]) r = r | (mask & ~(mask >> sh));
      end
      3'b011: r = ((d << sh) | (d >> (w - sh))) & mask;
      3'b100: r = ((d >> sh) | (d << (w - sh))) & mask;
      default: return {1'b1, d};
    endcase
    return {1'b0, r};
  endfunction

  // All drivers are entered and left at posedge+2.
  task automatic send32(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] m,
                        input logic [4:0] t, input logic [31:0] ed, input logic ee, input bit lat);
    int g = 0;
    b32.in_valid = 1'b1;
    b32.in_data  = d;
    b32.in_shamt = sh;
    b32.in_mode  = m;
    b32.in_tag   = t;
    #1;
    while (!b32.in_ready && g < 200) begin
      @(posedge clock); #3;
      g++;
    end
    if (!b32.in_ready) check("accept32_in_ready", b32.in_ready, 1'b1);
    else sb32.push_back('{ed, t, ee, cyc, lat});
    @(posedge clock); #2;
  endtask

  task automatic send8(input logic [7:0] d, input logic [2:0] sh, input logic [2:0] m,
                       input logic [4:0] t, input logic [31:0] ed, input logic ee, input bit lat);
    int g = 0;
    b8.in_valid = 1'b1;
    b8.in_data  = d;
    b8.in_shamt = sh;
    b8.in_mode  = m;
    b8.in_tag   = t;
    #1;
    while (!b8.in_ready && g < 200) begin
      @(posedge clock); #3;
      g++;
    end
    if (!b8.in_ready) check("accept8_in_ready", b8.in_ready, 1'b1);
    else sb8.push_back('{ed, t, ee, cyc, lat});
    @(posedge clock); #2;
  endtask

  task automatic drain32();
    int g = 0;
    b32.in_valid = 1'b0;
    while (sb32.size() != 0 && g < 300) begin
      @(posedge clock); #2;
      g++;
    end
    check("drain32_pending", sb32.size(), 0);
  endtask

  task automatic drain8();
    int g = 0;
    b8.in_valid = 1'b0;
    while (sb8.size() != 0 && g < 300) begin
      @(posedge clock); #2;
      g++;
    end
    check("drain8_pending", sb8.size(), 0);
  endtask

  task automatic monitor32();
    bit   held = 1'b0;
    exp_t hv;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        held = 1'b0;
        continue;
      end
      if (!b32.in_ready) rdy_low32++;
      if (held) begin
        check("hold32_valid", b32.out_valid, 1'b1);
        check("hold32_data", b32.out_data, hv.data);
        check("hold32_tag", b32.out_tag, hv.tag);
        check("hold32_err", b32.out_err, hv.err);
      end
      if (b32.out_valid && b32.out_ready) begin
        outs32++;
        if (sb32.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious32: got tag %0d, expected no output", b32.out_tag);
        end else begin
          e = sb32.pop_front();
          check("out32_tag", b32.out_tag, e.tag);
          check("out32_data", b32.out_data, e.data);
          check("out32_err", b32.out_err, e.err);
          if (e.lat) check("latency32", cyc - e.cyc, 5);
        end
      end
      held = b32.out_valid && !b32.out_ready;
      hv   = '{b32.out_data, b32.out_tag, b32.out_err, 0, 1'b0};
    end
  endtask

  task automatic monitor8();
    bit   held = 1'b0;
    exp_t hv;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        check("hold8_data", b8.out_data, hv.data);
        check("hold8_tag", b8.out_tag, hv.tag);
      end
      if (b8.out_valid && b8.out_ready) begin
        outs8++;
        if (sb8.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious8: got tag %0d, expected no output", b8.out_tag);
        end else begin
          e = sb8.pop_front();
          check("out8_tag", b8.out_tag, e.tag);
          check("out8_data", b8.out_data, e.data);
          check("out8_err", b8.out_err, e.err);
          if (e.lat) check("latency8", cyc - e.cyc, 3);
        end
      end
      held = b8.out_valid && !b8.out_ready;
      hv   = '{32'(b8.out_data), b8.out_tag, b8.out_err, 0, 1'b0};
    end
  endtask

  initial begin
    int          start_low;
    int          start_out;
    logic [32:0] m;
    logic [31:0] d;
    logic [4:0]  sh;
    logic [2:0]  md;

    vecs[0]  = '{32'h0000_0001,  5'd31, MODE_SLL, 32'h8000_0000, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF,  5'd31, MODE_SRL, 32'h0000_0001, 1'b0};
    vecs[2]  = '{32'hFFFF_FFFF,  5'd0,  MODE_SRL, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{32'h8000_00F0,  5'd4,  MODE_SRA, 32'hF800_000F, 1'b0};
    vecs[4]  = '{32'h7000_0000,  5'd4,  MODE_SRA, 32'h0700_0000, 1'b0};
    vecs[5]  = '{32'h1234_5678,  5'd8,  MODE_ROR, 32'h7812_3456, 1'b0};
    vecs[6]  = '{32'h8000_0001,  5'd1,  MODE_ROL, 32'h0000_0003, 1'b0};
    vecs[7]  = '{32'hDEAD_BEEF,  5'd7,  3'b111,   32'hDEAD_BEEF, 1'b1};
    vecs[8]  = '{32'h0000_00FF,  5'd4,  MODE_SLL, 32'h0000_0FF0, 1'b0};
    vecs[9]  = '{32'h8000_0000,  5'd31, MODE_SRA, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{32'h0000_0001,  5'd31, MODE_ROR, 32'h0000_0002, 1'b0};
    vecs[11] = '{32'h1234_5678,  5'd0,  3'b101,   32'h1234_5678, 1'b1};
    vecs[12] = '{32'hA5A5_0F0F,  5'd0,  MODE_ROL, 32'hA5A5_0F0F, 1'b0};

    b32.in_valid = 1'b0; b32.in_data = '0; b32.in_shamt = '0; b32.in_mode = '0;
    b32.in_tag = '0; b32.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.in_shamt = '0; b8.in_mode = '0;
    b8.in_tag = '0; b8.out_ready = 1'b1;

    fork
      monitor32();
      monitor8();
    join_none

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst32_out_valid", b32.out_valid, 1'b0);
    check("rst32_out_data", b32.out_data, 32'h0);
    check("rst32_out_tag", b32.out_tag, 5'h0);
    check("rst32_out_err", b32.out_err, 1'b0);
    check("rst8_out_valid", b8.out_valid, 1'b0);
    @(posedge clock); #2;
    reset = 1'b1;
    @(negedge clock);
    check("rst32_in_ready", b32.in_ready, 1'b1);
    check("rst8_in_ready", b8.in_ready, 1'b1);
    @(posedge clock); #2;

    // Directed vectors, one at a time, latency checked.
    for (int i = 0; i < 13; i++) begin
      send32(vecs[i].din, vecs[i].shamt, vecs[i].mode, 5'(i), vecs[i].dout, vecs[i].err, 1'b1);
      drain32();
    end

    // Eight back-to-back ops with a three-cycle consumer stall mid-stream.
    start_low = rdy_low32;
    start_out = outs32;
    fork
      begin
        for (int t = 0; t < 8; t++) begin
          d  = $urandom;
          sh = 5'($urandom_range(0, 31));
          md = 3'($urandom_range(0, 4));
          m  = model(32, d, int'(sh), md);
          send32(d, sh, md, 5'(t), m[31:0], m[32], 1'b0);
        end
        b32.in_valid = 1'b0;
      end
      begin
        int g = 0;
        while (!b32.out_valid && g < 50) begin
          @(posedge clock); #2;
          g++;
        end
        b32.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        b32.out_ready = 1'b1;
      end
    join
    drain32();
    check("stall32_in_ready_low_cycles", rdy_low32 - start_low, 3);
    check("stream32_outputs", outs32 - start_out, 8);

    // Reset with three ops in flight and a fourth offered during reset.
    for (int t = 20; t < 23; t++) begin
      m = model(32, 32'h0F0F_0000 + 32'(t), 3, MODE_ROL);
      send32(32'h0F0F_0000 + 32'(t), 5'd3, MODE_ROL, 5'(t), m[31:0], m[32], 1'b0);
    end
    start_out = outs32;
    b32.in_tag = 5'd23;
    reset = 1'b0;
    sb32.delete();
    @(posedge clock); #2;
    reset = 1'b1;
    b32.in_valid = 1'b0;
    @(negedge clock);
    check("midrst32_out_valid", b32.out_valid, 1'b0);
    check("midrst32_out_data", b32.out_data, 32'h0);
    check("midrst32_in_ready", b32.in_ready, 1'b1);
    @(posedge clock); #2;
    repeat (12) begin
      @(posedge clock); #2;
    end
    check("midrst32_no_outputs", outs32 - start_out, 0);

    // Eight-bit instance: directed cases with latency.
    send8(8'h81, 3'd4, MODE_ROL, 5'd1, 32'h18, 1'b0, 1'b1);
    drain8();
    send8(8'h90, 3'd3, MODE_SRA, 5'd2, 32'hF2, 1'b0, 1'b1);
    drain8();

    // Eight-bit instance: random ops against the model with random backpressure.
    start_out = outs8;
    fork
      begin
        logic [7:0] d8;
        logic [2:0] s8;
        logic [2:0] m8;
        for (int i = 0; i < 10000; i++) begin
          d8 = 8'($urandom);
          s8 = 3'($urandom_range(0, 7));
          m8 = 3'($urandom_range(0, 7));
          m  = model(8, 32'(d8), int'(s8), m8);
          send8(d8, s8, m8, 5'(i), m[31:0], m[32], 1'b0);
        end
        b8.in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock); #2;
          b8.out_ready = ($urandom_range(0, 3) != 0);
        end
        b8.out_ready = 1'b1;
      end
    join
    drain8();
    check("random8_outputs", outs8 - start_out, 10000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
